// File: rtl/calculadora_troco.sv
// Change-dispensing cashier FSM: collects notes, signals payment, pulses change or refunds one real at a time.
// Optional inactivity refund in COLETA is enabled with macro CALC_TROCO_TIMEOUT_EN.
module calculadora_troco #(
  parameter int INTERVALO      = 4,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INICIA,
  input  logic [1:0] PRECO_SEL,
  input  logic       INSERIR,
  input  logic [1:0] VALOR_CEDULA,
  input  logic       CANCELA,
  output logic [4:0] CREDITO,
  output logic       PAGO,
  output logic       TROCO_PULSO,
  output logic       REJEITA,
  output logic       ESTORNO,
  output logic [1:0] ESTADO
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    COLETA   = 2'b01,
    DISPENSA = 2'b10
  } estado_t;

  localparam int            IW      = $clog2(INTERVALO);
  localparam logic [IW-1:0] INT_ULT = IW'(INTERVALO - 1);

  estado_t       state_q, state_d;
  logic [2:0]    preco_q, preco_d;
  logic [4:0]    credito_q, credito_d;
  logic          pago_q, pago_d;
  logic          troco_q, troco_d;
  logic          rejeita_q, rejeita_d;
  logic          estorno_q, estorno_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [4:0]    soma;
  logic [4:0]    preco_ext;

`ifdef CALC_TROCO_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TW-1:0] TO_ULT = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  function automatic logic [4:0] valor_nota(input logic [1:0] cod);
    case (cod)
      2'b00:   valor_nota = 5'd1;
      2'b01:   valor_nota = 5'd2;
      2'b10:   valor_nota = 5'd5;
      default: valor_nota = 5'd10;
    endcase
  endfunction

  assign soma      = credito_q + valor_nota(VALOR_CEDULA);
  assign preco_ext = {2'b00, preco_q};

  always_comb begin
    state_d   = state_q;
    preco_d   = preco_q;
    credito_d = credito_q;
    pago_d    = 1'b0;
    troco_d   = 1'b0;
    rejeita_d = 1'b0;
    estorno_d = estorno_q;
    cnt_d     = cnt_q;
`ifdef CALC_TROCO_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      OCIOSO: begin
        rejeita_d = INSERIR;
        if (INICIA) begin
          preco_d   = 3'd3 + {1'b0, PRECO_SEL};
          credito_d = 5'd0;
          state_d   = COLETA;
`ifdef CALC_TROCO_TIMEOUT_EN
          to_d      = '0;
`endif
        end
      end
      COLETA: begin
        if (CANCELA) begin
          // Abort wins over a note arriving on the same edge; that note is refused.
          rejeita_d = INSERIR;
          cnt_d     = '0;
          if (credito_q == 5'd0) begin
            state_d = OCIOSO;
          end else begin
            state_d   = DISPENSA;
            estorno_d = 1'b1;
          end
        end else if (INSERIR) begin
`ifdef CALC_TROCO_TIMEOUT_EN
          to_d = '0;
`endif
          if (soma >= preco_ext) begin
            pago_d    = 1'b1;
            credito_d = soma - preco_ext;
            estorno_d = 1'b0;
            cnt_d     = '0;
            state_d   = (soma == preco_ext) ? OCIOSO : DISPENSA;
          end else begin
            credito_d = soma;
          end
        end
`ifdef CALC_TROCO_TIMEOUT_EN
        else if (to_q == TO_ULT) begin
          cnt_d = '0;
          if (credito_q != 5'd0) begin
            state_d   = DISPENSA;
            estorno_d = 1'b1;
          end else begin
            state_d = OCIOSO;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      DISPENSA: begin
        rejeita_d = INSERIR;
        if (cnt_q == INT_ULT) begin
          cnt_d = '0;
          if (credito_q != 5'd0) begin
            troco_d   = 1'b1;
            credito_d = credito_q - 5'd1;
            if (credito_q == 5'd1) begin
              state_d   = OCIOSO;
              estorno_d = 1'b0;
            end
          end else begin
            state_d   = OCIOSO;
            estorno_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = OCIOSO;
        estorno_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= OCIOSO;
      preco_q   <= 3'd0;
      credito_q <= 5'd0;
      pago_q    <= 1'b0;
      troco_q   <= 1'b0;
      rejeita_q <= 1'b0;
      estorno_q <= 1'b0;
      cnt_q     <= '0;
`ifdef CALC_TROCO_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      preco_q   <= preco_d;
      credito_q <= credito_d;
      pago_q    <= pago_d;
      troco_q   <= troco_d;
      rejeita_q <= rejeita_d;
      estorno_q <= estorno_d;
      cnt_q     <= cnt_d;
`ifdef CALC_TROCO_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign CREDITO     = credito_q;
  assign PAGO        = pago_q;
  assign TROCO_PULSO = troco_q;
  assign REJEITA     = rejeita_q;
  assign ESTORNO     = estorno_q;
  assign ESTADO      = state_q;

endmodule

// File: tb/tb_calculadora_troco.sv
// Directed bench for calculadora_troco: per-cycle expected outputs queued when driven, checked after the edge.
module tb_calculadora_troco;

  logic       CLK = 1'b0;
  logic       RST;
  logic       INICIA;
  logic [1:0] PRECO_SEL;
  logic       INSERIR;
  logic [1:0] VALOR_CEDULA;
  logic       CANCELA;
  logic [4:0] CREDITO;
  logic       PAGO;
  logic       TROCO_PULSO;
  logic       REJEITA;
  logic       ESTORNO;
  logic [1:0] ESTADO;

  typedef struct packed {
    logic [4:0] cr;
    logic       pago;
    logic       troco;
    logic       rej;
    logic       est;
    logic [1:0] st;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  calculadora_troco #(.INTERVALO(4), .TIMEOUT_CICLOS(16)) dut (
    .CLK(CLK), .RST(RST), .INICIA(INICIA), .PRECO_SEL(PRECO_SEL),
    .INSERIR(INSERIR), .VALOR_CEDULA(VALOR_CEDULA), .CANCELA(CANCELA),
    .CREDITO(CREDITO), .PAGO(PAGO), .TROCO_PULSO(TROCO_PULSO),
    .REJEITA(REJEITA), .ESTORNO(ESTORNO), .ESTADO(ESTADO)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t o(input int cr, input bit pago, input bit troco,
                             input bit rej, input bit est, input int st);
    obs_t r;
    r.cr = 5'(cr); r.pago = pago; r.troco = troco; r.rej = rej; r.est = est; r.st = 2'(st);
    return r;
  endfunction

  task automatic compare_front();
    obs_t  act, exp;
    string tag;
    act = '{CREDITO, PAGO, TROCO_PULSO, REJEITA, ESTORNO, ESTADO};
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total++;
    assert (act === exp)
    else begin
      bad++;
      $error("FAIL %s observed cr=%0d pago=%b troco=%b rej=%b est=%b st=%b expected cr=%0d pago=%b troco=%b rej=%b est=%b st=%b",
             tag, act.cr, act.pago, act.troco, act.rej, act.est, act.st,
             exp.cr, exp.pago, exp.troco, exp.rej, exp.est, exp.st);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
  task automatic cyc(input bit ini, input logic [1:0] psel, input bit ins,
                     input logic [1:0] val, input bit can, input obs_t exp, input string tag);
    INICIA = ini; PRECO_SEL = psel; INSERIR = ins; VALOR_CEDULA = val; CANCELA = can;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    INICIA = 1'b0; INSERIR = 1'b0; CANCELA = 1'b0;
    compare_front();
  endtask

  task automatic nop(input int n, input obs_t exp, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 2'b00, 0, exp, tag);
  endtask

  task automatic chk_now(input obs_t exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    compare_front();
  endtask

  initial begin
    RST = 1'b1; INICIA = 1'b0; PRECO_SEL = 2'b00; INSERIR = 1'b0;
    VALOR_CEDULA = 2'b00; CANCELA = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_now(o(0,0,0,0,0,0), "reset");
    RST = 1'b0;

    // Price 3, note 5: change 2, pulses 4 and 8 cycles after PAGO.
    cyc(1, 2'b00, 0, 2'b00, 0, o(0,0,0,0,0,1), "t1_inicia");
    cyc(0, 2'b00, 1, 2'b10, 0, o(2,1,0,0,0,2), "t1_pago");
    nop(3, o(2,0,0,0,0,2), "t1_wait1");
    nop(1, o(1,0,1,0,0,2), "t1_pulse1");
    nop(3, o(1,0,0,0,0,2), "t1_wait2");
    nop(1, o(0,0,1,0,0,0), "t1_pulse2");
    nop(2, o(0,0,0,0,0,0), "t1_idle");

    // Price 6, notes 1,2,2,1: exact payment, no change.
    cyc(1, 2'b11, 0, 2'b00, 0, o(0,0,0,0,0,1), "t2_inicia");
    cyc(0, 2'b00, 1, 2'b00, 0, o(1,0,0,0,0,1), "t2_n1");
    cyc(0, 2'b00, 1, 2'b01, 0, o(3,0,0,0,0,1), "t2_n2");
    cyc(0, 2'b00, 1, 2'b01, 0, o(5,0,0,0,0,1), "t2_n3");
    cyc(0, 2'b00, 1, 2'b00, 0, o(0,1,0,0,0,0), "t2_pago");
    nop(6, o(0,0,0,0,0,0), "t2_no_troco");

    // Price 5, note 2, then CANCELA with INSERIR: refund of 2.
    cyc(1, 2'b10, 0, 2'b00, 0, o(0,0,0,0,0,1), "t3_inicia");
    cyc(0, 2'b00, 1, 2'b01, 0, o(2,0,0,0,0,1), "t3_n1");
    cyc(0, 2'b00, 1, 2'b11, 1, o(2,0,0,1,1,2), "t3_cancela");
    nop(3, o(2,0,0,0,1,2), "t3_wait1");
    nop(1, o(1,0,1,0,1,2), "t3_pulse1");
    nop(3, o(1,0,0,0,1,2), "t3_wait2");
    nop(1, o(0,0,1,0,0,0), "t3_pulse2");
    nop(6, o(0,0,0,0,0,0), "t3_no_more");

    // Note in OCIOSO is refused.
    cyc(0, 2'b00, 1, 2'b10, 0, o(0,0,0,1,0,0), "t4_rejeita");
    nop(1, o(0,0,0,0,0,0), "t4_after");

    // Price 4, notes 2 and 5: change 3, reset after the first pulse.
    cyc(1, 2'b01, 0, 2'b00, 0, o(0,0,0,0,0,1), "t5_inicia");
    cyc(0, 2'b00, 1, 2'b01, 0, o(2,0,0,0,0,1), "t5_n1");
    cyc(0, 2'b00, 1, 2'b10, 0, o(3,1,0,0,0,2), "t5_pago");
    nop(3, o(3,0,0,0,0,2), "t5_wait1");
    nop(1, o(2,0,1,0,0,2), "t5_pulse1");
    RST = 1'b1;
    #1;
    chk_now(o(0,0,0,0,0,0), "t5_rst_async");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    nop(10, o(0,0,0,0,0,0), "t5_no_troco");

    // Price 6, note 1, then long inactivity.
    cyc(1, 2'b11, 0, 2'b00, 0, o(0,0,0,0,0,1), "t6_inicia");
    cyc(0, 2'b00, 1, 2'b00, 0, o(1,0,0,0,0,1), "t6_n1");
`ifdef CALC_TROCO_TIMEOUT_EN
    nop(15, o(1,0,0,0,0,1), "t6_waiting");
    nop(1, o(1,0,0,0,1,2), "t6_timeout");
    nop(3, o(1,0,0,0,1,2), "t6_wait1");
    nop(1, o(0,0,1,0,0,0), "t6_pulse1");
    nop(4, o(0,0,0,0,0,0), "t6_idle");
`else
    nop(24, o(1,0,0,0,0,1), "t6_stays");
    cyc(0, 2'b00, 0, 2'b00, 1, o(1,0,0,0,1,2), "t6_cancela");
    nop(3, o(1,0,0,0,1,2), "t6_wait1");
    nop(1, o(0,0,1,0,0,0), "t6_pulse1");
    nop(4, o(0,0,0,0,0,0), "t6_idle");
`endif

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain observed=%0d pending expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calculadora_troco.md
CALCULADORA_TROCO -- requirements
Module: calculadora_troco

Interface
REQ-001 SHALL have parameter INTERVALO, default 4: clock cycles between consecutive TROCO_PULSO pulses (>=2).
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 16: idle cycles in COLETA before automatic refund (used only with CALC_TROCO_TIMEOUT_EN).
REQ-003 SHALL have port CLK  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port INICIA  input  1: one-cycle pulse that opens a purchase session.
REQ-006 SHALL have port PRECO_SEL  input  2: price code 00=3, 01=4, 10=5, 11=6 reais.
REQ-007 SHALL have port INSERIR  input  1: one-cycle pulse, one note inserted.
REQ-008 SHALL have port VALOR_CEDULA  input  2: note code 00=1, 01=2, 10=5, 11=10 reais, sampled with INSERIR.
REQ-009 SHALL have port CANCELA  input  1: one-cycle pulse, user abort.
REQ-010 SHALL have port CREDITO  output  5: registered credit, or change remaining while dispensing.
REQ-011 SHALL have port PAGO  output  1: one-cycle pulse, price reached.
REQ-012 SHALL have port TROCO_PULSO  output  1: one-cycle pulse per 1 real returned.
REQ-013 SHALL have port REJEITA  output  1: one-cycle pulse, note refused.
REQ-014 SHALL have port ESTORNO  output  1: level, high while dispensing a refund instead of change.
REQ-015 SHALL have port ESTADO  output  2: state code OCIOSO=00, COLETA=01, DISPENSA=10.

Function
REQ-016 SHALL implement FSM OCIOSO, COLETA, DISPENSA; all outputs registered.
REQ-017 SHALL, in OCIOSO on INICIA, latch PRECO_SEL into an internal price register, clear CREDITO and enter COLETA; PRECO_SEL changes afterwards are ignored until the next session.
REQ-018 SHALL, in COLETA on INSERIR, add the note value to CREDITO on the same edge (5-bit unsigned, max reachable 15, no overflow).
REQ-019 SHALL, when the sum is >= price, on that same edge assert PAGO for one cycle, load CREDITO = sum - price, clear ESTORNO and enter DISPENSA, or OCIOSO if the difference is 0.
REQ-020 SHALL, in COLETA on CANCELA, enter DISPENSA with ESTORNO=1 and CREDITO unchanged, or OCIOSO if CREDITO=0.
REQ-021 SHALL give CANCELA priority over a simultaneous INSERIR: the note is not added and REJEITA pulses.
REQ-022 SHALL pulse REJEITA for one cycle on INSERIR in OCIOSO or DISPENSA, with CREDITO unchanged.
REQ-023 SHALL ignore INICIA outside OCIOSO and CANCELA outside COLETA.
REQ-024 SHALL, in DISPENSA, pulse TROCO_PULSO every INTERVALO cycles, the first pulse INTERVALO cycles after entry, decrementing CREDITO on each pulse edge; on the edge CREDITO reaches 0, enter OCIOSO and clear ESTORNO.
REQ-025 SHALL never emit TROCO_PULSO when CREDITO=0.

Reset
REQ-026 SHALL, while RST=1, force state OCIOSO, price register 0, CREDITO=0, PAGO=0, TROCO_PULSO=0, REJEITA=0, ESTORNO=0, ESTADO=00 and clear all counters.
REQ-027 SHALL, on reset mid-DISPENSA, discard the remaining change with no further TROCO_PULSO.

Configuration
REQ-028 SHALL, with macro CALC_TROCO_TIMEOUT_EN defined, count cycles in COLETA since entry or the last accepted note; at TIMEOUT_CICLOS, enter DISPENSA with ESTORNO=1 if CREDITO>0, otherwise OCIOSO.
REQ-029 SHALL, without CALC_TROCO_TIMEOUT_EN, stay in COLETA indefinitely, with no timeout counter present.

Verification
REQ-030 SHALL cover: INICIA with PRECO_SEL=00, INSERIR 10=5 -> next cycle PAGO=1, CREDITO=2, ESTADO=10; TROCO_PULSO 4 and 8 cycles later; then OCIOSO, CREDITO=0.
REQ-031 SHALL cover: PRECO_SEL=11, notes 1,2,2,1 -> CREDITO 1,3,5 then PAGO with CREDITO=0, direct to OCIOSO, no TROCO_PULSO.
REQ-032 SHALL cover: PRECO_SEL=10, note 2, then CANCELA and INSERIR in the same cycle -> REJEITA=1, ESTORNO=1, exactly 2 TROCO_PULSO, CREDITO stays 2 until the first pulse.
REQ-033 SHALL cover: INSERIR in OCIOSO -> REJEITA one cycle, CREDITO=0, ESTADO=00.
REQ-034 SHALL cover: RST asserted after the first of 3 change pulses -> outputs 0 immediately, no further TROCO_PULSO.
REQ-035 SHALL cover, with CALC_TROCO_TIMEOUT_EN: note 1 then 16 idle cycles -> ESTORNO=1, one TROCO_PULSO; without the macro -> remains in COLETA with CREDITO=1.
